// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter.
// The debug port is built only when DMEM_ARB_DBG_EN is defined.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } dmem_arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } dmem_arb_owner_t;

  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/dmem_arb_prio.sv
// Grant selection between CPU and debug, with the debug starvation counter.
// With DMEM_ARB_DBG_EN undefined the CPU is always the owner and no counter exists.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_req,
  input  logic            dbg_req,
  input  logic            grant,
  output dmem_arb_owner_t owner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

`ifdef DMEM_ARB_DBG_EN
  logic [3:0] starve_cnt_r;

  // Debug wins when the CPU is absent or debug has lost STARVE_MAX times in a row.
  always_comb begin
    owner = OWN_CPU;
    if (dbg_req && (!cpu_req || (starve_cnt_r == STARVE_LIM))) begin
      owner = OWN_DBG;
    end else begin
      owner = OWN_CPU;
    end
  end

  // Starvation counter: saturating count of CPU wins over a waiting debug port.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
    end else if (grant) begin
      if (owner == OWN_DBG) begin
        starve_cnt_r <= 4'd0;
      end else if (dbg_req && (starve_cnt_r != STARVE_LIM)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{clk, reset, cpu_req, dbg_req, grant, STARVE_LIM};
  assign owner    = OWN_CPU;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) request-acknowledge arbiter in front of Memoria64.
// Debug port functionality is enabled by defining DMEM_ARB_DBG_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CPU_REQ,
  input  logic              CPU_WR,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              CPU_ACK,
  output logic              CPU_STALL,
  input  logic              DBG_REQ,
  input  logic              DBG_WR,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_WDATA,
  output logic [DATA_W-1:0] DBG_RDATA,
  output logic              DBG_ACK,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WR,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  dmem_arb_state_t   state_r, next_s;
  dmem_arb_owner_t   owner_r, grant_owner_s;
  logic              wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [1:0]        lat_cnt_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic              cpu_ack_r;
  logic              req_any_s, grant_s, rd_done_s;

`ifdef DMEM_ARB_DBG_EN
  assign req_any_s = CPU_REQ | DBG_REQ;
`else
  assign req_any_s = CPU_REQ;
`endif
  assign grant_s   = (state_r == IDLE) && req_any_s;
  assign rd_done_s = (state_r == WAIT) && (lat_cnt_r == LAT_LAST);

  dmem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk     (CLK),
    .reset   (RESET),
    .cpu_req (CPU_REQ),
    .dbg_req (DBG_REQ),
    .grant   (grant_s),
    .owner   (grant_owner_s)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; DONE always falls back to IDLE so grants never chain.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_any_s) next_s = ISSUE;
        else           next_s = IDLE;
      end
      ISSUE: begin
        if (wr_r) next_s = DONE;
        else      next_s = WAIT;
      end
      WAIT: begin
        if (rd_done_s) next_s = DONE;
        else           next_s = WAIT;
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Request latch: owner and fields are frozen at grant, later changes ignored.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner_r <= OWN_CPU;
      wr_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (grant_s) begin
      owner_r <= grant_owner_s;
      if (grant_owner_s == OWN_DBG) begin
        wr_r    <= DBG_WR;
        addr_r  <= DBG_ADDR;
        wdata_r <= DBG_WDATA;
      end else begin
        wr_r    <= CPU_WR;
        addr_r  <= CPU_ADDR;
        wdata_r <= CPU_WDATA;
      end
    end else begin
      owner_r <= owner_r;
      wr_r    <= wr_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Read latency counter, running only while in WAIT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lat_cnt_r <= 2'd0;
    end else if (state_r == WAIT) begin
      lat_cnt_r <= lat_cnt_r + 2'd1;
    end else begin
      lat_cnt_r <= 2'd0;
    end
  end

  // CPU completion: ACK coincides with DONE, read data captured on the last WAIT cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cpu_ack_r   <= 1'b0;
      cpu_rdata_r <= {DATA_W{1'b0}};
    end else begin
      cpu_ack_r <= (next_s == DONE) && (owner_r == OWN_CPU);
      if (rd_done_s && (owner_r == OWN_CPU)) cpu_rdata_r <= MEM_RDATA;
      else                                   cpu_rdata_r <= cpu_rdata_r;
    end
  end

`ifdef DMEM_ARB_DBG_EN
  logic [DATA_W-1:0] dbg_rdata_r;
  logic              dbg_ack_r;

  // Debug completion, mirroring the CPU side.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dbg_ack_r   <= 1'b0;
      dbg_rdata_r <= {DATA_W{1'b0}};
    end else begin
      dbg_ack_r <= (next_s == DONE) && (owner_r == OWN_DBG);
      if (rd_done_s && (owner_r == OWN_DBG)) dbg_rdata_r <= MEM_RDATA;
      else                                   dbg_rdata_r <= dbg_rdata_r;
    end
  end

  assign DBG_RDATA = dbg_rdata_r;
  assign DBG_ACK   = dbg_ack_r;
`else
  assign DBG_RDATA = {DATA_W{1'b0}};
  assign DBG_ACK   = 1'b0;
`endif

  // RESET gates the strobe directly so an interrupted write never commits.
  assign MEM_WR    = (state_r == ISSUE) & wr_r & ~RESET;
  assign MEM_ADDR  = addr_r;
  assign MEM_WDATA = wdata_r;
  assign CPU_RDATA = cpu_rdata_r;
  assign CPU_ACK   = cpu_ack_r;
  assign CPU_STALL = CPU_REQ & ~cpu_ack_r;

endmodule
